masked_sbox_scheduler: RTL
==========================

// Module: masked_sbox_scheduler
// PURPOSE
//   Shares one pipelined masked AES S-box (masked_aes_sbox_fwd) between two
//   requesters: channel 0 is the state/SubBytes path, channel 1 is the key schedule.
//   Channels are granted round-robin. Fresh randomness is gated so the S-box consumes
//   randomness only in issue cycles. A tag pipeline routes each S-box result back to
//   the channel that issued it. The block sits between the round controller and the
//   S-box instance.
// PARAMETERS
//   NUM_SHARES  2  number of Boolean shares per byte (>=2)
//   LATENCY     3  S-box latency in cycles; must equal the S-box instance LATENCY (>=1)
//   NUM_RANDOM  -  width of the S-box randomness bus; set from num_bv8_inv_random(...)
// PORTS
//   in_clock          in   1                 clock
//   in_reset          in   1                 synchronous, active-high reset
//   in_req_valid      in   2                 per-channel request valid
//   out_req_ready     out  2                 per-channel grant; handshake = valid & ready
//   in_req_a          in   2 x NUM_SHARES x 8 per-channel masked input byte (bv8_t shares)
//   in_random_valid   in   1                 fresh randomness present on in_random
//   in_random         in   NUM_RANDOM        fresh randomness from the PRNG
//   out_random_ready  out  1                 randomness consumed this cycle
//   out_sbox_a        out  NUM_SHARES x 8    shares driven to the S-box in_a
//   out_sbox_random   out  NUM_RANDOM        randomness driven to the S-box in_random
//   in_sbox_b         in   NUM_SHARES x 8    S-box out_b
//   out_rsp_valid     out  2                 per-channel result valid (one-hot or zero)
//   out_rsp_b         out  NUM_SHARES x 8    masked result shares (common to both channels)
//   out_busy          out  1                 one or more S-box operations in flight
// BEHAVIOUR
//   - Issue condition: issue = in_random_valid & |in_req_valid.
//   - Arbitration: if only one channel is valid, grant that channel. If both are
//     valid, grant the channel other than last_grant. last_grant updates on each issue.
//   - Reset value of last_grant is 1, so the first contested grant goes to channel 0.
//   - out_req_ready is combinational from valid, the pointer and in_random_valid. It is
//     one-hot on issue and zero otherwise. Requesters must not make valid depend on ready.
//   - out_random_ready = issue. No channel is granted while in_random_valid=0. Requests
//     stay pending, and out_req_ready stays 0 on both channels.
//   - Issue cycle: out_sbox_a = granted in_req_a shares and out_sbox_random = in_random.
//   - Non-issue cycle: out_sbox_a and out_sbox_random are all-zero (no stale-share
//     transitions). A mux-select glitch must not combine shares of the two channels.
//     Select with registered-free AND-gating per channel followed by an OR.
//   - Tag pipeline: LATENCY registered stages of {valid, id}. Stage 0 is loaded with
//     {issue, granted id} each cycle and shifts every cycle; it never stalls. The S-box
//     pipeline is free-running, so the scheduler has no backpressure.
//   - Response: when the last stage is valid, out_rsp_valid[id]=1 and out_rsp_b=in_sbox_b.
//     Otherwise out_rsp_valid=0 and out_rsp_b is all-zero (AND-gated).
//   - Result latency is exactly LATENCY cycles after the handshake cycle.
//   - Throughput is 1 byte/cycle. Responses leave in issue order.
//   - Requesters must accept a response in the cycle it is presented.
//   - out_busy = OR of the valid bits in all tag stages.
//   - Reset: clears all tag valids and sets last_grant=1. All outputs read 0 during
//     reset and in the cycle after release until new issues occur.
//   - Reset mid-operation drops in-flight operations: no out_rsp_valid is raised for
//     them, even though S-box data still drains.
//   - Requests presented while in_reset=1 are not granted.
//   - Simultaneous issue and response in one cycle are independent; there is no hazard.
//   - Unmasked values are never formed: the block never XORs shares together.
// TESTING
//   1. Ch0 only, shares {0x5A,0x5A} (x=0x00), random valid -> ready[0] in cycle 0,
//      rsp_valid[0] at cycle 3, XOR of rsp shares = 0x63.
//   2. Both valid for 6 cycles from reset -> grants 0,1,0,1,0,1. rsp_valid follows the
//      same pattern delayed by 3 cycles.
//   3. Ch1 pending, in_random_valid=0 for 4 cycles -> out_req_ready=0,
//      out_random_ready=0, out_sbox_a=0. Grant occurs in the first cycle with
//      random valid.
//   4. Ch1 streams x=0x01,0x02,0x53 back-to-back -> three consecutive rsp_valid[1]
//      with unmasked results 0x7C,0x77,0xED.
//   5. Two ops in flight, then in_reset pulsed for 1 cycle -> no rsp_valid in the next
//      LATENCY cycles and out_busy=0. A following contested request goes to ch0.
//   6. Idle with random valid -> out_sbox_random=0, out_rsp_b=0, out_busy=0 on every cycle.

Source files
------------

// File: rtl/masked_sbox_scheduler.sv
// Round-robin front end that shares one pipelined masked AES S-box between the state path
// (channel 0) and the key schedule (channel 1), and routes each result back by tag.
`timescale 1ns/1ps
module masked_sbox_scheduler #(
    parameter int NUM_SHARES = 2,
    parameter int LATENCY    = 3,
    parameter int NUM_RANDOM = 36
) (
    input  logic                               in_clock,
    input  logic                               in_reset,
    input  logic [1:0]                         in_req_valid,
    output logic [1:0]                         out_req_ready,
    input  logic [1:0][NUM_SHARES-1:0][7:0]    in_req_a,
    input  logic                               in_random_valid,
    input  logic [NUM_RANDOM-1:0]              in_random,
    output logic                               out_random_ready,
    output logic [NUM_SHARES-1:0][7:0]         out_sbox_a,
    output logic [NUM_RANDOM-1:0]              out_sbox_random,
    input  logic [NUM_SHARES-1:0][7:0]         in_sbox_b,
    output logic [1:0]                         out_rsp_valid,
    output logic [NUM_SHARES-1:0][7:0]         out_rsp_b,
    output logic                               out_busy
);

    logic                last_grant_q;
    logic [LATENCY-1:0]  tag_valid_q;
    logic [LATENCY-1:0]  tag_id_q;

    logic                issue;
    logic                grant_id_d;
    logic [1:0]          grant;
    logic                rsp_live;

    // Nothing is granted while reset is asserted, so reset also masks the issue term.
    assign issue      = ~in_reset & in_random_valid & (|in_req_valid);
    assign grant_id_d = (&in_req_valid) ? ~last_grant_q : in_req_valid[1];
    assign grant[0]   = issue & ~grant_id_d;
    assign grant[1]   = issue &  grant_id_d;

    assign out_req_ready    = grant;
    assign out_random_ready = issue;
    assign out_sbox_random  = {NUM_RANDOM{issue}} & in_random;

    // Per-channel AND-gate then OR, so a select glitch can never mix shares of both channels.
    for (genvar gi = 0; gi < NUM_SHARES; gi++) begin : g_share
        assign out_sbox_a[gi] = ({8{grant[0]}} & in_req_a[0][gi])
                              | ({8{grant[1]}} & in_req_a[1][gi]);
        assign out_rsp_b[gi]  = {8{rsp_live}} & in_sbox_b[gi];
    end

    assign rsp_live         = tag_valid_q[LATENCY-1] & ~in_reset;
    assign out_rsp_valid[0] = rsp_live & ~tag_id_q[LATENCY-1];
    assign out_rsp_valid[1] = rsp_live &  tag_id_q[LATENCY-1];
    assign out_busy         = (|tag_valid_q) & ~in_reset;

    // Tag pipeline mirrors the free-running S-box; it shifts every cycle and never stalls.
    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            last_grant_q <= 1'b1;
            tag_valid_q  <= '0;
            tag_id_q     <= '0;
        end else begin
            if (issue) begin
                last_grant_q <= grant_id_d;
            end
            tag_valid_q[0] <= issue;
            tag_id_q[0]    <= issue & grant_id_d;
            for (int i = 1; i < LATENCY; i++) begin
                tag_valid_q[i] <= tag_valid_q[i-1];
                tag_id_q[i]    <= tag_id_q[i-1];
            end
        end
    end

endmodule
